// File: rtl/clock_pkg.sv
// Shared encodings, field widths and limits for the HH:MM:SS run/set controller.
package clock_pkg;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;

    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_SET_HR  = 3'd1;
    localparam logic [2:0] ST_SET_MIN = 3'd2;
    localparam logic [2:0] ST_SET_SEC = 3'd3;
    localparam logic [2:0] ST_LOAD    = 3'd4;

    typedef enum logic [2:0] {
        S_RUN     = ST_RUN,
        S_SET_HR  = ST_SET_HR,
        S_SET_MIN = ST_SET_MIN,
        S_SET_SEC = ST_SET_SEC,
        S_LOAD    = ST_LOAD
    } state_e;

    // Out-of-range captures (e.g. a corrupted counter) fall back to 0 like the wrap.
    function automatic logic [HR_W-1:0] hr_inc(input logic [HR_W-1:0] v);
        return (v >= HR_MAX) ? '0 : v + HR_W'(1);
    endfunction

    function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] v);
        return (v >= MIN_MAX) ? '0 : v + MIN_W'(1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter; wrap flags the cycle before the count reaches
// TICK_DIV-1 so registered consumers line up with the terminal count.
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic wrap
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(TICK_DIV - 2);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign wrap = !clr && (cnt_q == PRE);

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set controller: prescaled tick in RUN, capture/edit/load of HH:MM:SS otherwise.
// Buttons are single-cycle pulses; tick_en and load_en are single-cycle strobes, never together.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic [SEC_W-1:0] cur_sec,
    input  logic [MIN_W-1:0] cur_min,
    input  logic [HR_W-1:0]  cur_hr,
    output logic             tick_en,
    output logic             load_en,
    output logic [SEC_W-1:0] set_sec,
    output logic [MIN_W-1:0] set_min,
    output logic [HR_W-1:0]  set_hr,
    output logic [2:0]       mode,
    output logic             blink
);
    state_e           state_q, state_d;
    logic             clr, wrap, editing;
    logic [HR_W-1:0]  hr_q;
    logic [MIN_W-1:0] min_q;
    logic [SEC_W-1:0] sec_q;
    logic             tick_q, load_q, blink_q;
    logic [2:0]       mode_q;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .wrap  (wrap)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:     if (btn_mode) state_d = S_SET_HR;
            S_SET_HR:  if (btn_mode) state_d = S_SET_MIN;
            S_SET_MIN: if (btn_mode) state_d = S_SET_SEC;
            S_SET_SEC: if (btn_mode) state_d = S_LOAD;
            S_LOAD:    state_d = S_RUN;
            default:   state_d = S_RUN;
        endcase
    end

    // Any mode change restarts the prescaler so each mode starts on a fresh period.
    assign clr     = (state_d != state_q);
    assign editing = (state_q == S_SET_HR) || (state_q == S_SET_MIN) || (state_q == S_SET_SEC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            mode_q  <= ST_RUN;
            tick_q  <= 1'b0;
            load_q  <= 1'b0;
            blink_q <= 1'b0;
            hr_q    <= '0;
            min_q   <= '0;
            sec_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= state_d;
            tick_q  <= (state_d == S_RUN) && wrap;
            load_q  <= (state_d == S_LOAD);

            if (clr) begin
                blink_q <= 1'b0;
            end else if (editing && wrap) begin
                blink_q <= ~blink_q;
            end

            // btn_mode takes priority; a coincident btn_inc is dropped.
            if (state_q == S_RUN && btn_mode) begin
                hr_q  <= cur_hr;
                min_q <= cur_min;
                sec_q <= cur_sec;
            end else if (!btn_mode && btn_inc) begin
                case (state_q)
                    S_SET_HR:  hr_q  <= hr_inc(hr_q);
                    S_SET_MIN: min_q <= min_inc(min_q);
                    S_SET_SEC: sec_q <= '0;
                    default:   ;
                endcase
            end
        end
    end

    assign tick_en = tick_q;
    assign load_en = load_q;
    assign blink   = blink_q;
    assign mode    = mode_q;
    assign set_hr  = hr_q;
    assign set_min = min_q;
    assign set_sec = sec_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus random traffic, all outputs
// compared every cycle against a cycle-level behavioural model.
module tb_clock_set_ctrl;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [5:0] cur_sec = '0, cur_min = '0;
  logic [4:0] cur_hr = '0;
  logic       tick_en, load_en, blink;
  logic [5:0] set_sec, set_min;
  logic [4:0] set_hr;
  logic [2:0] mode;

  int n_checks = 0;
  int n_fail = 0;

  // model: 0=RUN 1=SET_HR 2=SET_MIN 3=SET_SEC 4=LOAD; cnt is the prescaler phase
  int m_state, m_cnt, m_hr, m_min, m_sec;
  bit m_blink;

  always #5 clk = ~clk;

  clock_set_ctrl #(.TICK_DIV(D)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hr(cur_hr),
    .tick_en(tick_en), .load_en(load_en),
    .set_sec(set_sec), .set_min(set_min), .set_hr(set_hr),
    .mode(mode), .blink(blink)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit bm, input bit bi,
                            input int ch, input int cm, input int cs);
    if (r) begin
      m_state = 0; m_cnt = 0; m_blink = 0; m_hr = 0; m_min = 0; m_sec = 0;
    end else if (m_state == 4) begin
      m_state = 0; m_cnt = 0; m_blink = 0;
    end else if (bm) begin
      if (m_state == 0) begin
        m_hr = ch; m_min = cm; m_sec = cs;
      end
      m_state = m_state + 1; m_cnt = 0; m_blink = 0;
    end else begin
      if (bi) begin
        if (m_state == 1) m_hr = (m_hr >= 23) ? 0 : m_hr + 1;
        if (m_state == 2) m_min = (m_min >= 59) ? 0 : m_min + 1;
        if (m_state == 3) m_sec = 0;
      end
      m_cnt = (m_cnt + 1) % D;
      if (m_state != 0 && m_cnt == D - 1) m_blink = !m_blink;
    end
  endtask

  task automatic step(input bit r, input bit bm, input bit bi);
    reset = r; btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    model_step(r, bm, bi, int'(cur_hr), int'(cur_min), int'(cur_sec));
    #1;
    check("mode", mode, m_state);
    check("tick_en", tick_en, (m_state == 0 && m_cnt == D - 1));
    check("load_en", load_en, (m_state == 4));
    check("blink", blink, m_blink);
    check("set_hr", set_hr, m_hr);
    check("set_min", set_min, m_min);
    check("set_sec", set_sec, m_sec);
    check("tick_load_excl", tick_en && load_en, 0);
    reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  task automatic back_to_run(); // from any set state
    while (m_state != 0) step(0, (m_state != 4), 0);
  endtask

  initial begin
    int toggles;
    bit prev_blink;
    logic [5:0] min_before;

    // 1: reset state and tick cadence, cycle 1 = first cycle after the reset edge
    step(1, 0, 0);
    step(1, 0, 0);
    check("t1_reset_mode", mode, 0);
    check("t1_reset_tick", tick_en, 0);
    check("t1_reset_load", load_en, 0);
    for (int cyc = 2; cyc <= 12; cyc++) begin
      step(0, 0, 0);
      check("t1_tick", tick_en, (cyc % 4 == 0));
      check("t1_load", load_en, 0);
    end

    // 2: full edit round trip from 23:58:30
    cur_hr = 5'd23; cur_min = 6'd58; cur_sec = 6'd30;
    step(0, 1, 0); check("t2_mode_hr", mode, 1); check("t2_cap_hr", set_hr, 23);
    step(0, 0, 1); check("t2_hr_wrap", set_hr, 0);
    step(0, 1, 0); check("t2_mode_min", mode, 2);
    step(0, 0, 1); check("t2_min_59", set_min, 59);
    step(0, 0, 1); check("t2_min_wrap", set_min, 0);
    step(0, 1, 0); check("t2_mode_sec", mode, 3);
    step(0, 0, 1); check("t2_sec_clr", set_sec, 0);
    step(0, 1, 0);
    check("t2_load", load_en, 1); check("t2_load_mode", mode, 4);
    check("t2_ld_hr", set_hr, 0); check("t2_ld_min", set_min, 0); check("t2_ld_sec", set_sec, 0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0);
      check("t2_post_load", load_en, 0);
      check("t2_first_tick", tick_en, (k == 4));
      if (k == 1) check("t2_back_run", mode, 0);
    end

    // 3: simultaneous buttons in SET_MIN
    cur_hr = 5'd10; cur_min = 6'd20; cur_sec = 6'd30;
    step(0, 1, 0); step(0, 1, 0); step(0, 0, 1);
    min_before = set_min;
    check("t3_min_21", min_before, 21);
    step(0, 1, 1);
    check("t3_mode", mode, 3);
    check("t3_min_kept", set_min, min_before);
    back_to_run();

    // 4: blink cadence in SET_HR, no tick
    step(0, 1, 0);
    toggles = 0; prev_blink = blink;
    check("t4_blink_init", blink, 0);
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0);
      if (blink != prev_blink) toggles++;
      prev_blink = blink;
      check("t4_blink", blink, ((k >= 3) + (k >= 7) + (k >= 11)) % 2);
      check("t4_no_tick", tick_en, 0);
    end
    check("t4_toggles", toggles, 3);
    back_to_run();

    // 5: reset mid-edit discards edits
    step(0, 1, 0); step(0, 0, 1); step(0, 1, 0); step(0, 0, 1); step(0, 1, 0);
    check("t5_in_sec", mode, 3);
    step(1, 0, 0);
    check("t5_mode", mode, 0); check("t5_load", load_en, 0);
    check("t5_hr", set_hr, 0); check("t5_min", set_min, 0); check("t5_sec", set_sec, 0);
    for (int cyc = 2; cyc <= 8; cyc++) begin
      step(0, 0, 0);
      check("t5_load_q", load_en, 0);
      check("t5_tick", tick_en, (cyc % 4 == 0));
    end

    // 6: out-of-range hour capture
    cur_hr = 5'd25;
    step(0, 1, 0); check("t6_cap", set_hr, 25);
    step(0, 0, 1); check("t6_hr_zero", set_hr, 0);
    back_to_run();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cur_hr  = 5'($urandom_range(0, 31));
      cur_min = 6'($urandom_range(0, 63));
      cur_sec = 6'($urandom_range(0, 63));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Run/set controller for the HH:MM:SS time counter. In RUN it issues a prescaled one-second tick enable to the counter. On operator buttons it captures the current time, lets hours, minutes and seconds be edited, then issues a one-cycle parallel load back into the counter. It sits between the debounced button front-end and the loadable time counter.

Parameters:
TICK_DIV, 4, clk cycles per tick_en pulse (>=2); prescaler width is $clog2(TICK_DIV).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_mode  input  1  single-cycle pulse (already debounced): advance edit mode
btn_inc  input  1  single-cycle pulse (already debounced): increment/clear selected field
cur_sec  input  6  live seconds from time counter
cur_min  input  6  live minutes from time counter
cur_hr  input  5  live hours from time counter
tick_en  output  1  one-cycle count enable to time counter
load_en  output  1  one-cycle parallel-load strobe to time counter
set_sec  output  6  seconds value to load
set_min  output  6  minutes value to load
set_hr  output  5  hours value to load
mode  output  3  current state code
blink  output  1  display blink for the field being edited

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- States and mode codes: RUN=0, SET_HR=1, SET_MIN=2, SET_SEC=3, LOAD=4. mode is registered from the state.
- Reset: state RUN; prescaler 0; edit regs 0; tick_en, load_en and blink 0; mode 0. Reset mid-edit discards the edits, and no load is issued.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - tick_en=1 for exactly the cycle in which the prescaler equals TICK_DIV-1.
  - On btn_mode: capture cur_hr/cur_min/cur_sec into the edit regs on that edge, go to SET_HR, clear the prescaler.
- SET_HR / SET_MIN / SET_SEC:
  - tick_en held 0; the prescaler keeps running.
  - blink toggles on each prescaler wrap.
  - On btn_inc:
    - SET_HR: hr+1, 23 wraps to 0; any captured value >=23 goes to 0.
    - SET_MIN: min+1, 59 wraps to 0; any value >=59 goes to 0.
    - SET_SEC: sec cleared to 0.
  - btn_mode advances SET_HR->SET_MIN->SET_SEC->LOAD.
  - On every mode change, blink is cleared to 0 and the prescaler is cleared.
- LOAD: lasts one cycle.
  - load_en=1 and set_* are stable with the edited values.
  - Next state is RUN with the prescaler at 0, so the first tick_en comes TICK_DIV cycles after the load cycle.
  - Buttons are ignored in LOAD.
- set_* continuously reflect the edit regs; they are valid only while load_en=1.
- Simultaneous btn_mode and btn_inc: btn_mode wins and btn_inc is dropped.
- load_en and tick_en are never high in the same cycle. tick_en is never asserted outside RUN.
- All outputs are registered. Button-to-state-change latency is 1 cycle.

Decomposition:
- Shared package clock_pkg:
  - state encoding localparams ST_RUN..ST_LOAD (3 bits);
  - limits HR_MAX=23, MIN_MAX=59, SEC_MAX=59;
  - field widths 5/6/6.
- One sub-module, tick_prescaler (params TICK_DIV; ports clk, reset, clr, wrap).
  - Instantiated once.
  - The FSM uses wrap for tick_en in RUN and for blink in the set states.

Test Plan:
1. TICK_DIV=4. Release reset at a known cycle -> tick_en pulses on cycles 4, 8, 12 after release, each exactly 1 cycle wide; mode=0; load_en stays 0.
2. cur=23:58:30, then btn_mode -> mode=1 next cycle; btn_inc once -> hr edit=0; btn_mode; btn_inc twice -> min 58->59->0.
   - Continue: btn_mode; btn_inc -> sec=0; btn_mode -> LOAD.
   - Required: one cycle with load_en=1 and set_hr=0, set_min=0, set_sec=0; mode returns to 0; first tick_en exactly 4 cycles later.
3. In SET_MIN, pulse btn_mode and btn_inc in the same cycle -> mode=3, and min is unchanged.
4. In SET_HR, hold for 12 cycles -> blink toggles every 4 cycles; tick_en stays 0 throughout.
5. Assert reset while in SET_SEC with edited values -> next cycle mode=0, set_* are 0, no load_en pulse, tick_en resumes after TICK_DIV cycles.
6. Capture cur_hr=25 (out of range), then btn_inc in SET_HR -> hr edit=0.
